// File: rtl/alu_issue_if.sv
// Bundle between ID, the alu_issue slot and the ALU inputs.
// When ILLEGAL_OP_EN is defined, the bundle also carries illegal_o.
interface alu_issue_if #(
  parameter int data_width = 32
) ();
  logic                  flush_i;
  logic                  valid_i;
  logic                  ready_o;
  logic [5:0]            opcode_i;
  logic [5:0]            funct_i;
  logic [15:0]           imm_i;
  logic [data_width-1:0] rs_data_i;
  logic [data_width-1:0] rt_data_i;
  logic                  valid_o;
  logic                  ready_i;
  logic [2:0]            ALUop_o;
  logic [data_width-1:0] data_1_o;
  logic [data_width-1:0] data_2_o;
`ifdef ILLEGAL_OP_EN
  logic                  illegal_o;
`endif

  // Issue unit side: drives the ALU inputs and back-pressures ID.
  modport master (
    input  flush_i, valid_i, opcode_i, funct_i, imm_i, rs_data_i, rt_data_i, ready_i,
`ifdef ILLEGAL_OP_EN
    output illegal_o,
`endif
    output ready_o, valid_o, ALUop_o, data_1_o, data_2_o
  );

  modport slave (
    output flush_i, valid_i, opcode_i, funct_i, imm_i, rs_data_i, rt_data_i, ready_i,
`ifdef ILLEGAL_OP_EN
    input  illegal_o,
`endif
    input  ready_o, valid_o, ALUop_o, data_1_o, data_2_o
  );
endinterface

// File: rtl/alu_issue.sv
// EX-stage issue slot: decodes opcode/funct to an ALU op, selects operand 2 and holds MUL operands.
// Optional macro ILLEGAL_OP_EN adds illegal_o flagging unlisted encodings.
module alu_issue #(
  parameter int data_width = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  alu_issue_if.master  bus
);

  typedef enum logic [2:0] {
    ADD_alu = 3'b000,
    SUB_alu = 3'b001,
    MUL_alu = 3'b010,
    AND_alu = 3'b011,
    OR_alu  = 3'b100
  } alu_op_t;

  typedef enum logic [1:0] {IDLE, MWAIT, FULL} state_t;

  localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  state_t                state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  alu_op_t               op_dec, op_r;
  logic [data_width-1:0] op2_dec, d1_r, d2_r;
  logic                  mul_dec;
  logic                  load, transfer, load_en;

  logic [data_width-1:0] imm_sext, imm_zext;
  assign imm_sext = {{(data_width-16){bus.imm_i[15]}}, bus.imm_i};
  assign imm_zext = {{(data_width-16){1'b0}}, bus.imm_i};

  // Unlisted encodings fall through to ADD with rt, matching a plain add.
  always_comb begin
    op_dec  = ADD_alu;
    op2_dec = bus.rt_data_i;
    mul_dec = 1'b0;
    case (bus.opcode_i)
      6'h00: begin
        case (bus.funct_i)
          6'h22: op_dec = SUB_alu;
          6'h18: begin
            op_dec  = MUL_alu;
            mul_dec = 1'b1;
          end
          6'h24: op_dec = AND_alu;
          6'h25: op_dec = OR_alu;
          default: op_dec = ADD_alu;
        endcase
      end
      6'h08, 6'h23, 6'h2B: op2_dec = imm_sext;
      6'h04: op_dec = SUB_alu;
      6'h0C: begin
        op_dec  = AND_alu;
        op2_dec = imm_zext;
      end
      6'h0D: begin
        op_dec  = OR_alu;
        op2_dec = imm_zext;
      end
      default: op_dec = ADD_alu;
    endcase
  end

  assign bus.valid_o = (state == FULL);
  assign bus.ready_o = (state == IDLE) || ((state == FULL) && bus.ready_i);
  assign load        = bus.valid_i && bus.ready_o;
  assign transfer    = bus.valid_o && bus.ready_i;
  assign load_en     = load && !bus.flush_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (bus.flush_i) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE, FULL: begin
          if (load) begin
            if (mul_dec && (MUL_CYCLES > 1)) begin
              state_n = MWAIT;
              cnt_n   = CW'(MUL_CYCLES - 1);
            end else begin
              state_n = FULL;
            end
          end else if (transfer) begin
            state_n = IDLE;
          end
        end
        MWAIT: begin
          if (cnt == CW'(1)) begin
            state_n = FULL;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Slot contents move only on an accepted, unflushed load; flush leaves them as-is.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_r <= ADD_alu;
      d1_r <= '0;
      d2_r <= '0;
    end else if (load_en) begin
      op_r <= op_dec;
      d1_r <= bus.rs_data_i;
      d2_r <= op2_dec;
    end
  end

  assign bus.ALUop_o  = op_r;
  assign bus.data_1_o = d1_r;
  assign bus.data_2_o = d2_r;

`ifdef ILLEGAL_OP_EN
  logic legal_dec, illegal_r;

  assign legal_dec = ((bus.opcode_i == 6'h00) &&
                      (bus.funct_i inside {6'h20, 6'h22, 6'h18, 6'h24, 6'h25})) ||
                     (bus.opcode_i inside {6'h08, 6'h23, 6'h2B, 6'h04, 6'h0C, 6'h0D});

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) illegal_r <= 1'b0;
    else if (load_en)         illegal_r <= !legal_dec;
  end

  assign bus.illegal_o = illegal_r;
`endif

endmodule
